// File: rtl/seg_port_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_port_pkg : FSM state type, segment constants and pow10 helper for seg_port_bank
// Rev 1.0
// ---------------------------------------------------------------------------
package seg_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low gfedcba patterns; digit n lives at [n*7 +: 7].
  localparam logic [69:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [127:0] pow10(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 128'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_to_seg7 : one BCD digit to active-low 7-segment pattern with blank/dash override
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import seg_port_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blank; out-of-range nibbles fall back to blank.
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank && (digit <= 4'd9)) begin
      seg = SEG_TABLE[7*digit +: 7];
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_port_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_port_bank : round-robin double-dabble of NPORTS ports onto 7-seg digits (opt. SEG_PORT_OVF_DASH_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_port_bank
  import seg_port_pkg::*;
#(
  parameter int NPORTS        = 3,
  parameter int WIDTH         = 32,
  parameter int DIGITS        = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS*WIDTH-1:0]    port_in,
  input  logic                       freeze,
  output logic [NPORTS*DIGITS*7-1:0] hex_out,
  output logic [NPORTS-1:0]          ovf,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int BCD_W = 4 * DIGITS;

  // When 10^DIGITS does not fit in WIDTH bits, no port value can overflow.
  localparam logic [127:0]     POW_FULL   = pow10(DIGITS);
  localparam bit               LIMIT_FITS = (WIDTH >= 128) || (POW_FULL < (128'd1 << WIDTH));
  localparam logic [WIDTH-1:0] OVF_LIMIT  = WIDTH'(POW_FULL);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [WIDTH-1:0]    bin;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_pending;

  logic [WIDTH-1:0]    load_val;
  logic                load_ovf;
  logic [BCD_W-1:0]    adj;
  logic [DIGITS-1:0]   blank_vec;
  logic                dash_flag;
  logic [DIGITS*7-1:0] seg_word;

  assign load_val = port_in[idx*WIDTH +: WIDTH];
  assign load_ovf = LIMIT_FITS && (load_val >= OVF_LIMIT);

`ifdef SEG_PORT_OVF_DASH_EN
  assign dash_flag = ovf_pending;
`else
  assign dash_flag = 1'b0;
`endif

  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  // A digit blanks only if it and every more significant displayed digit are zero.
  always_comb begin : b_blank
    logic upper_zero;
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      upper_zero   = upper_zero && (bcd[d*4 +: 4] == 4'd0);
      blank_vec[d] = (BLANK_LEADING != 0) && (d != 0) && upper_zero;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_to_seg7 u_seg (
      .digit (bcd[d*4 +: 4]),
      .blank (blank_vec[d]),
      .dash  (dash_flag),
      .seg   (seg_word[d*7 +: 7])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      bin         <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      hex_out     <= '1;
      ovf         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!freeze) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          bin         <= load_val;
          bcd         <= '0;
          cnt         <= '0;
          ovf_pending <= load_ovf;
          state       <= SHIFT;
        end
        SHIFT: begin
          // Carry out of the top nibble is dropped, leaving value mod 10^DIGITS.
          {bcd, bin} <= {adj, bin} << 1;
          cnt        <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          hex_out[idx*DIGITS*7 +: DIGITS*7] <= seg_word;
          ovf[idx]                          <= ovf_pending;
          if (idx == IDX_W'(NPORTS - 1)) begin
            idx        <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
            if (freeze) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_port_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_port_bank : randomized self-checking bench against a behavioural display model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seg_port_bank;

  localparam int NP       = 3;
  localparam int W        = 32;
  localparam int D        = 2;
  localparam int DW       = D * 7;
  localparam int PORT_CYC = W + 2;
  localparam int FRAME    = NP * PORT_CYC + 1;
  localparam longint unsigned LIM = 64'd10 ** D;

`ifdef SEG_PORT_OVF_DASH_EN
  localparam bit DASH_EN = 1'b1;
`else
  localparam bit DASH_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            freeze = 1'b0;
  logic [NP*W-1:0] port_in = '0;

  logic [NP*DW-1:0] hex_out, hex_nb;
  logic [NP-1:0]    ovf, ovf_nb;
  logic             busy, busy_nb, frame_done, fd_nb;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_lut [10];

  always #5 clk = ~clk;

  seg_port_bank #(.NPORTS(NP), .WIDTH(W), .DIGITS(D), .BLANK_LEADING(1)) dut (
    .clk(clk), .reset(reset), .port_in(port_in), .freeze(freeze),
    .hex_out(hex_out), .ovf(ovf), .busy(busy), .frame_done(frame_done)
  );

  seg_port_bank #(.NPORTS(NP), .WIDTH(W), .DIGITS(D), .BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .port_in(port_in), .freeze(freeze),
    .hex_out(hex_nb), .ovf(ovf_nb), .busy(busy_nb), .frame_done(fd_nb)
  );

  // Display model: digits of (v mod 10^D), leading-zero blanking, optional dash on overflow.
  function automatic logic [DW-1:0] model_hex(input logic [W-1:0] v, input bit bl);
    longint unsigned m, p;
    logic [DW-1:0] r;
    m = 64'(v) % LIM;
    p = 1;
    r = '0;
    for (int d = 0; d < D; d++) begin
      if (DASH_EN && (64'(v) >= LIM)) r[d*7 +: 7] = 7'h3F;
      else if (bl && d > 0 && m < p)  r[d*7 +: 7] = 7'h7F;
      else                            r[d*7 +: 7] = seg_lut[int'((m / p) % 10)];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [NP*DW-1:0] model_all(input logic [NP*W-1:0] pv, input bit bl);
    logic [NP*DW-1:0] r;
    for (int p = 0; p < NP; p++) r[p*DW +: DW] = model_hex(pv[p*W +: W], bl);
    return r;
  endfunction

  function automatic logic [NP-1:0] model_ovf(input logic [NP*W-1:0] pv);
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (64'(pv[p*W +: W]) >= LIM);
    return r;
  endfunction

  function automatic logic [DW-1:0] field(input logic [NP*DW-1:0] h, input int p);
    return h[p*DW +: DW];
  endfunction

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 9));
      1:       return W'($urandom_range(10, 99));
      2:       return W'($urandom_range(100, 999));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input int limit, output int cycles, output bit ok);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_done !== 1'b1 && cycles < limit);
    ok = (frame_done === 1'b1);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    freeze = 1'b0;
    for (int p = 0; p < NP; p++) port_in[p*W +: W] = $urandom;
    tick(3);
    total++; if (hex_out !== '1) begin bad++; $display("FAIL reset_hex got=%h exp=all ones", hex_out); end
    total++; if (hex_nb !== '1) begin bad++; $display("FAIL reset_hex_nb got=%h exp=all ones", hex_nb); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_first_frame();
    logic [NP*W-1:0] pv;
    int load_k, fd_k;
    pv = '0;
    pv[W-1:0] = W'(42);
    port_in = pv;
    load_k = -1;
    fd_k = -1;
    reset = 1'b1;
    for (int k = 1; k <= FRAME + 20 && fd_k < 0; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && load_k < 0) load_k = k;
      if (frame_done === 1'b1) fd_k = k;
    end
    total++; if (load_k != 1) begin bad++; $display("FAIL first_load got=%0d exp=1", load_k); end
    total++; if (fd_k - load_k + 1 != FRAME) begin bad++; $display("FAIL frame_latency got=%0d exp=%0d", fd_k - load_k + 1, FRAME); end
    total++; if (field(hex_out, 0) !== {7'b0011001, 7'b0100100}) begin bad++; $display("FAIL port0_42 got=%h exp=%h", field(hex_out, 0), {7'b0011001, 7'b0100100}); end
    total++; if (field(hex_out, 1) !== {7'h7F, 7'b1000000}) begin bad++; $display("FAIL port1_zero got=%h exp=%h", field(hex_out, 1), {7'h7F, 7'b1000000}); end
    total++; if (hex_out !== model_all(pv, 1'b1)) begin bad++; $display("FAIL first_hex got=%h exp=%h", hex_out, model_all(pv, 1'b1)); end
    total++; if (hex_nb !== model_all(pv, 1'b0)) begin bad++; $display("FAIL first_hex_nb got=%h exp=%h", hex_nb, model_all(pv, 1'b0)); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL first_ovf got=%b exp=0", ovf); end
    tick(1);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fd_pulse got=%b exp=0", frame_done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL next_frame_busy got=%b exp=1", busy); end
  endtask

  task automatic test_values();
    logic [NP*W-1:0] pv;
    int n;
    bit ok;
    wait_fd(FRAME + 10, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL values_sync got=timeout exp=frame_done"); end
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NP; p++) pv[p*W +: W] = rand_val();
      if (r == 0) begin
        pv[W +: W]   = W'(7);
        pv[2*W +: W] = W'(105);
      end
      port_in = pv;
      wait_fd(FRAME + 10, n, ok);
      total++; if (!ok || n != FRAME) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", n, FRAME); end
      total++; if (hex_out !== model_all(pv, 1'b1)) begin bad++; $display("FAIL values_hex r=%0d got=%h exp=%h", r, hex_out, model_all(pv, 1'b1)); end
      total++; if (hex_nb !== model_all(pv, 1'b0)) begin bad++; $display("FAIL values_hex_nb r=%0d got=%h exp=%h", r, hex_nb, model_all(pv, 1'b0)); end
      total++; if (ovf !== model_ovf(pv)) begin bad++; $display("FAIL values_ovf r=%0d got=%b exp=%b", r, ovf, model_ovf(pv)); end
      if (r == 0) begin
        total++; if (field(hex_out, 1) !== {7'h7F, 7'b1111000}) begin bad++; $display("FAIL blank_7 got=%h exp=%h", field(hex_out, 1), {7'h7F, 7'b1111000}); end
        total++; if (field(hex_nb, 1) !== {7'b1000000, 7'b1111000}) begin bad++; $display("FAIL noblank_7 got=%h exp=%h", field(hex_nb, 1), {7'b1000000, 7'b1111000}); end
        total++; if (field(hex_out, 2) !== (DASH_EN ? {7'h3F, 7'h3F} : {7'h7F, 7'b0010010})) begin bad++; $display("FAIL ovf_105 got=%h", field(hex_out, 2)); end
        total++; if (ovf[2] !== 1'b1) begin bad++; $display("FAIL ovf2_flag got=%b exp=1", ovf[2]); end
      end
    end
  endtask

  task automatic test_stale_update();
    logic [NP*W-1:0] pv;
    logic [DW-1:0] e42, e99;
    int n;
    bit ok;
    bit seen_fd;
    e42 = model_hex(W'(42), 1'b1);
    e99 = model_hex(W'(99), 1'b1);
    pv = port_in;
    pv[W-1:0] = W'(42);
    port_in = pv;
    wait_fd(FRAME + 10, n, ok);
    total++; if (!ok) begin bad++; $display("FAIL stale_sync got=timeout exp=frame_done"); end
    tick(10);
    pv[W-1:0] = W'(99);
    port_in = pv;
    seen_fd = 1'b0;
    for (int k = 11; k <= FRAME + 10 && !seen_fd; k++) begin
      @(negedge clk);
      total++; if (field(hex_out, 0) !== e42) begin bad++; $display("FAIL hold_42 k=%0d got=%h exp=%h", k, field(hex_out, 0), e42); end
      seen_fd = (frame_done === 1'b1);
    end
    total++; if (!seen_fd) begin bad++; $display("FAIL stale_fd1 got=timeout exp=frame_done"); end
    seen_fd = 1'b0;
    for (int k = 1; k <= FRAME + 10 && !seen_fd; k++) begin
      @(negedge clk);
      total++; if (field(hex_out, 0) !== e42 && field(hex_out, 0) !== e99) begin bad++; $display("FAIL glitch_port0 k=%0d got=%h exp=%h_or_%h", k, field(hex_out, 0), e42, e99); end
      seen_fd = (frame_done === 1'b1);
    end
    total++; if (!seen_fd || field(hex_out, 0) !== e99) begin bad++; $display("FAIL show_99 got=%h exp=%h", field(hex_out, 0), e99); end
  endtask

  task automatic test_freeze();
    logic [NP*W-1:0] pv;
    logic [NP*DW-1:0] snap;
    int changes, busy_hi, fd_j;
    bit busy_j1;
    // Entered on a frame_done cycle; the next edge loads port 0.
    pv = port_in;
    pv[W +: W]   = rand_val();
    pv[2*W +: W] = rand_val();
    port_in = pv;
    tick(45);
    freeze = 1'b1;
    tick(23);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL freeze_commit_busy got=%b exp=1", busy); end
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL freeze_busy_drop got=%b exp=0", busy); end
    total++; if (field(hex_out, 1) !== model_hex(pv[W +: W], 1'b1)) begin bad++; $display("FAIL freeze_port1 got=%h exp=%h", field(hex_out, 1), model_hex(pv[W +: W], 1'b1)); end
    pv[2*W +: W] = W'($urandom_range(100, 99999));
    port_in = pv;
    snap = hex_out;
    changes = 0;
    busy_hi = 0;
    repeat (500) begin
      @(negedge clk);
      if (hex_out !== snap) changes++;
      if (busy !== 1'b0 || frame_done !== 1'b0) busy_hi++;
    end
    total++; if (changes != 0) begin bad++; $display("FAIL freeze_hold_hex got=%0d exp=0", changes); end
    total++; if (busy_hi != 0) begin bad++; $display("FAIL freeze_hold_busy got=%0d exp=0", busy_hi); end
    freeze = 1'b0;
    fd_j = -1;
    busy_j1 = 1'b0;
    for (int j = 1; j <= PORT_CYC + 10 && fd_j < 0; j++) begin
      @(negedge clk);
      if (j == 1) busy_j1 = busy;
      if (frame_done === 1'b1) fd_j = j;
    end
    total++; if (busy_j1 !== 1'b1) begin bad++; $display("FAIL unfreeze_busy got=%b exp=1", busy_j1); end
    total++; if (fd_j != PORT_CYC + 1) begin bad++; $display("FAIL unfreeze_port2 got=%0d exp=%0d", fd_j, PORT_CYC + 1); end
    total++; if (hex_out !== model_all(pv, 1'b1)) begin bad++; $display("FAIL unfreeze_hex got=%h exp=%h", hex_out, model_all(pv, 1'b1)); end
    total++; if (ovf !== model_ovf(pv)) begin bad++; $display("FAIL unfreeze_ovf got=%b exp=%b", ovf, model_ovf(pv)); end
  endtask

  task automatic test_reset_mid();
    logic [NP*W-1:0] pv;
    int n;
    bit ok;
    total++; if (ovf[2] !== 1'b1) begin bad++; $display("FAIL pre_reset_ovf got=%b exp=1", ovf[2]); end
    for (int p = 0; p < NP; p++) pv[p*W +: W] = rand_val();
    port_in = pv;
    tick(50);
    #2 reset = 1'b0;
    #1;
    total++; if (hex_out !== '1 || hex_nb !== '1) begin bad++; $display("FAIL async_hex got=%h exp=all ones", hex_out); end
    total++; if (ovf !== '0) begin bad++; $display("FAIL async_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset = 1'b1;
    tick(PORT_CYC + 1);
    total++; if (field(hex_out, 0) !== model_hex(pv[W-1:0], 1'b1)) begin bad++; $display("FAIL restart_port0 got=%h exp=%h", field(hex_out, 0), model_hex(pv[W-1:0], 1'b1)); end
    total++; if (hex_out[NP*DW-1:DW] !== '1) begin bad++; $display("FAIL restart_others got=%h exp=all ones", hex_out[NP*DW-1:DW]); end
    wait_fd(FRAME + 10, n, ok);
    total++; if (!ok || n + PORT_CYC + 1 != FRAME) begin bad++; $display("FAIL restart_latency got=%0d exp=%0d", n + PORT_CYC + 1, FRAME); end
    total++; if (hex_out !== model_all(pv, 1'b1)) begin bad++; $display("FAIL restart_hex got=%h exp=%h", hex_out, model_all(pv, 1'b1)); end
    total++; if (ovf !== model_ovf(pv)) begin bad++; $display("FAIL restart_ovf got=%b exp=%b", ovf, model_ovf(pv)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_values();
    test_stale_update();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
